// File: rtl/stack_ptr_unit.sv
// Stack-pointer register with a valid/ready command port: INC, DEC, byte-serial LOAD and signed REL add.
// Define STACK_LIMIT_EN to suppress out-of-range updates and raise the sticky fault flag.
module stack_ptr_unit #(
    parameter int          SP_WIDTH    = 16,
    parameter int          STEP        = 1,
    parameter logic [31:0] RESET_VALUE = 32'h0000_FFFE,
    parameter logic [31:0] LIMIT_LO    = 32'h0000_0000,
    parameter logic [31:0] LIMIT_HI    = 32'h0000_FFFF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [7:0]          data_bus,
    input  logic                byte_valid,
    output logic [SP_WIDTH-1:0] sp,
    output logic                flag_h,
    output logic                flag_c,
    output logic                busy,
    output logic                fault
);

`ifdef STACK_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    localparam int NBYTES = SP_WIDTH / 8;
    localparam int CNT_W  = 2;
    localparam logic [SP_WIDTH-1:0] STEP_V  = SP_WIDTH'(STEP);
    localparam logic [SP_WIDTH-1:0] RESET_V = RESET_VALUE[SP_WIDTH-1:0];
    localparam logic [SP_WIDTH-1:0] LO_V    = LIMIT_LO[SP_WIDTH-1:0];
    localparam logic [SP_WIDTH-1:0] HI_V    = LIMIT_HI[SP_WIDTH-1:0];
    localparam logic [CNT_W-1:0]    LAST_B  = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_LOAD = 3'd3,
        OP_REL  = 3'd4
    } op_e;

    typedef enum logic {IDLE, LOAD} state_e;

    state_e                      state, state_next;
    logic [CNT_W-1:0]            counter;
    logic [NBYTES-2:0][7:0]      buffer;
    logic [SP_WIDTH-1:0]         sp_cand;
    logic                        upd_sp, upd_flags, wrap, h_next, c_next, violate;
    logic [4:0]                  sum_lo4;
    logic [8:0]                  sum_lo8;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == LOAD);

    assign sum_lo4 = {1'b0, sp[3:0]} + {1'b0, data_bus[3:0]};
    assign sum_lo8 = {1'b0, sp[7:0]} + {1'b0, data_bus};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        upd_sp     = 1'b0;
        upd_flags  = 1'b0;
        wrap       = 1'b0;
        sp_cand    = sp;
        h_next     = sum_lo4[4];
        c_next     = sum_lo8[8];
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_INC: begin
                            upd_sp          = 1'b1;
                            {wrap, sp_cand} = {1'b0, sp} + {1'b0, STEP_V};
                        end
                        OP_DEC: begin
                            upd_sp          = 1'b1;
                            {wrap, sp_cand} = {1'b0, sp} - {1'b0, STEP_V};
                        end
                        OP_REL: begin
                            upd_sp    = 1'b1;
                            upd_flags = 1'b1;
                            sp_cand   = sp + {{(SP_WIDTH-8){data_bus[7]}}, data_bus};
                        end
                        OP_LOAD: state_next = LOAD;
                        default: ;
                    endcase
                end
            end
            LOAD: begin
                if (byte_valid && counter == LAST_B) begin
                    upd_sp     = 1'b1;
                    sp_cand    = {data_bus, buffer};
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign violate = LIMIT_EN && upd_sp && (wrap || sp_cand < LO_V || sp_cand > HI_V);

    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sp      <= RESET_V;
            flag_h  <= 1'b0;
            flag_c  <= 1'b0;
            fault   <= 1'b0;
            counter <= '0;
            buffer  <= '0;
        end else begin
            state <= state_next;
            if (upd_sp && !violate)
                sp <= sp_cand;
            if (upd_flags) begin
                flag_h <= h_next;
                flag_c <= c_next;
            end
            if (violate)
                fault <= 1'b1;
            if (state == IDLE) begin
                counter <= '0;
            end else if (byte_valid) begin
                if (counter == LAST_B) begin
                    counter <= '0;
                end else begin
                    for (int i = 0; i < NBYTES - 1; i++)
                        if (counter == CNT_W'(i))
                            buffer[i] <= data_bus;
                    counter <= counter + 1'b1;
                end
            end
        end
    end

endmodule
